laplacian_sharpen: RTL
======================

# laplacian_sharpen

Streaming 3x3 negative-Laplacian engine that produces the `sharpened_image` operand for the downstream sharpening adder. The adder is a one-cycle registered stage that computes `out = sharpened_image + img`. This block accepts a raster-order 8-bit grayscale pixel stream and buffers two lines. For each output it emits the signed high-pass term together with the co-aligned centre pixel `img`, so the adder can sum them directly.

## Interface
- `IMG_W`, default 640: pixels per line; must be ≥ 3.
- `IMG_H`, default 480: lines per frame; must be ≥ 3.
- `width`, default 10: MSB index of the signed output (output is `width+1` bits); must be ≥ 10.
- `clk`  in  1: single clock; all logic on posedge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: `in_pixel` is valid this cycle.
- `in_sof`  in  1: start of frame; qualified by `in_valid`; marks `in_pixel` as position (0,0).
- `in_pixel`  in  8: unsigned input pixel, raster order.
- `out_valid`  out  1: `img` and `sharpened_image` are valid this cycle.
- `img`  out  8: unsigned centre pixel, aligned to `sharpened_image`.
- `sharpened_image`  out  `width+1`: signed value 4·C − U − D − L − R.

## Operation
- Column counter x runs 0..IMG_W−1 and row counter y runs 0..IMG_H−1. Both advance only on accepted pixels (`in_valid`=1).
  - x wraps to 0 and y increments at x=IMG_W−1.
  - y wraps to 0 after the last pixel of the frame.
- `in_valid` & `in_sof`: the pixel is taken as (0,0) regardless of the counters. The counters continue from (1,0).
- Line buffers:
  - Two IMG_W×8 memories hold rows y−1 and y−2, indexed by x.
  - Each accepted pixel is written at index x. The row shifts at line wrap.
  - Inferred RAM or register arrays are both acceptable.
- Output generation:
  - Each accepted pixel at (x,y) with x≥1 and y≥1 produces exactly one output for centre (x−1, y−1).
  - Accepted pixels with x=0 or y=0 produce no output.
- Output frame is therefore (IMG_W−1)×(IMG_H−1) centres: columns 0..IMG_W−2 and rows 0..IMG_H−2. The last column and last row are never emitted as centres.
- Window for centre (cx,cy):
  - C = (cx,cy)
  - U = (cx,cy−1)
  - D = (cx,cy+1), which is the current input row
  - L = (cx−1,cy)
  - R = (cx+1,cy)
- Border rule: if cx=0 or cy=0, `sharpened_image`=0 and `img`=C.
- Arithmetic:
  - Neighbours are zero-extended to `width+1` bits.
  - 4·C is computed as C<<2 with no truncation.
  - The result is exact, with range −1020..+1020.
  - No saturation is applied here; the adder consumer handles range.
- There is no backpressure. The consumer must accept every `out_valid` beat.

## Timing
- Latency: fixed 2 cycles.
  - An input accepted at edge N produces `out_valid`=1 after edge N+2.
  - Stage 1 registers the window and partial sums.
  - Stage 2 registers the outputs.
- Throughput: one pixel per cycle. Gaps in `in_valid` produce matching gaps in `out_valid`, shifted by 2 cycles.
- Outputs are registered. While `out_valid`=0, `img` and `sharpened_image` hold their last values.
- Reset (`rst_n`=0 at a posedge):
  - x, y ← 0.
  - `out_valid`, `img`, `sharpened_image` ← 0.
  - Both pipeline stages are flushed; in-flight results are discarded.
  - Line-buffer contents are don't-care, because no output can be produced before the first row has been rewritten.
- Reset mid-frame: following pixels are treated as the start of a new frame. This holds even without `in_sof`.
- `in_sof` mid-frame:
  - Counters resync to (0,0) on that pixel.
  - Outputs already in the pipeline still complete.
  - The old frame's partial row is not emitted further.
- `in_sof` at (0,0) is a no-op.
- Back-to-back frames: the last pixel of frame k and the first pixel of frame k+1 may be consecutive with no gap. The frame k+1 row-0 pixel produces no output.

## Test plan
- Flat frame, 8×8, all pixels 100, continuous `in_valid`:
  - Expect exactly 49 outputs.
  - Every output has `img`=100 and `sharpened_image`=0.
  - The first `out_valid` is 2 cycles after pixel (1,1).
- Impulse, 8×8, zeros except (3,3)=200:
  - Centre (3,3) gives +800.
  - Centres (2,3), (4,3), (3,2), (3,4) give −200.
  - All others give 0, including border centres.
- Extremes:
  - Centre 255 with neighbours 0 gives +1020.
  - Centre 0 with neighbours 255 gives −1020.
  - Sign and width are checked at `width`=10.
- Stalls: impulse frame with random `in_valid` gaps (~50%) gives results identical to the impulse case. Each output occurs exactly 2 cycles after its triggering input.
- Resync and reset:
  - Assert `rst_n`=0 midway through row 4, then send a full flat-50 frame. Expect exactly 49 outputs, all 50/0, and none from before reset after the reset edge.
  - Repeat with `in_sof` midway instead of reset. Same result.
- Back-to-back frames:
  - Send two 8×8 frames with no gap: first all 10, second all 90.
  - Expect 98 outputs: 49 with `img`=10, then 49 with `img`=90.
  - All have `sharpened_image`=0; no cross-frame contamination at border centres.

Source files
------------

// File: rtl/laplacian_sharpen.sv
// laplacian_sharpen: streaming 3x3 negative-Laplacian (4C-U-D-L-R) with two line buffers.
// Each output carries the co-aligned centre pixel so a downstream adder can sum them directly.
module laplacian_sharpen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int width = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [7:0]              in_pixel,
  output logic                    out_valid,
  output logic [7:0]              img,
  output logic signed [width:0]   sharpened_image
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  logic [XW-1:0] x_q, x_d, xe;
  logic [YW-1:0] y_q, y_d, ye;
  logic [7:0] lb1_q [IMG_W];
  logic [7:0] lb2_q [IMG_W];
  logic v0_q, emit0_q, bord0_q;
  logic [7:0] pix0_q, top0_q, mid0_q;
  logic v1_q, bord1_q;
  logic [7:0] cu_q, cm_q, cd_q, lm_q, cen_q;
  logic [9:0] s4_q, ns_q;
  // in_sof forces the current pixel to (0,0) regardless of the counters
  always_comb begin
    xe = in_sof ? '0 : x_q;
    ye = in_sof ? '0 : y_q;
    x_d = (xe == XW'(IMG_W - 1)) ? '0 : xe + 1'b1;
    y_d = (xe != XW'(IMG_W - 1)) ? ye : (ye == YW'(IMG_H - 1)) ? '0 : ye + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (in_valid) begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  // Per-column shift: lb1 holds row y-1, lb2 holds row y-2 at each x
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1_q[xe] <= in_pixel;
      lb2_q[xe] <= lb1_q[xe];
      pix0_q    <= in_pixel;
      top0_q    <= lb2_q[xe];
      mid0_q    <= lb1_q[xe];
      emit0_q   <= (|xe) && (|ye);
      bord0_q   <= (xe == XW'(1)) || (ye == YW'(1));
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      v0_q <= in_valid;
      v1_q <= v0_q & emit0_q;
    end
  end
  // Window: cm/cu/cd is the centre column, lm its left neighbour, mid0 the right one
  always_ff @(posedge clk) begin
    if (v0_q) begin
      cu_q    <= top0_q;
      cm_q    <= mid0_q;
      cd_q    <= pix0_q;
      lm_q    <= cm_q;
      cen_q   <= cm_q;
      s4_q    <= {cm_q, 2'b00};
      ns_q    <= 10'(cu_q) + 10'(cd_q) + 10'(lm_q) + 10'(mid0_q);
      bord1_q <= bord0_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      img             <= '0;
      sharpened_image <= '0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        img             <= cen_q;
        sharpened_image <= bord1_q ? '0 : $signed((width + 1)'(s4_q) - (width + 1)'(ns_q));
      end
    end
  end
endmodule
